// File: rtl/imem_loader_pkg.sv
// ============================================================================
// Module      : imem_loader_pkg
// Description : Shared state encoding and defaults for the instruction-memory
//               stream loader.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package imem_loader_pkg;

    localparam int IM_ADDR_W_DEFAULT = 12;

    typedef enum logic [2:0] {
        ST_LOAD  = 3'd0,
        ST_WRITE = 3'd1,
        ST_CHECK = 3'd2,
        ST_DONE  = 3'd3,
        ST_ERR   = 3'd4
    } state_t;

endpackage

`default_nettype wire

// File: rtl/imem_word_packer.sv
// ============================================================================
// Module      : imem_word_packer
// Description : Packs big-endian bytes into words; flags word completion and
//               an image that ends on a partial word.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module imem_word_packer #(
    parameter int BYTE_W = 8
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                i_clear,
    input  logic                i_accept,
    input  logic [BYTE_W-1:0]   i_data,
    input  logic                i_last,
    output logic                o_word_done,
    output logic                o_partial,
    output logic [4*BYTE_W-1:0] o_word,
    output logic                o_word_last
);

    localparam int WORD_W = 4 * BYTE_W;

    logic [1:0]        r_cnt;
    logic [WORD_W-1:0] r_buf;
    logic              r_last;

    // Both strobes are combinational so the FSM can leave LOAD on the accepting edge.
    assign o_word_done = i_accept && (r_cnt == 2'd3);
    assign o_partial   = i_accept && i_last && (r_cnt != 2'd3);
    assign o_word      = r_buf;
    assign o_word_last = r_last;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_cnt  <= '0;
            r_buf  <= '0;
            r_last <= 1'b0;
        end else if (i_clear) begin
            r_cnt  <= '0;
            r_buf  <= '0;
            r_last <= 1'b0;
        end else if (i_accept) begin
            r_buf <= {r_buf[WORD_W-BYTE_W-1:0], i_data};
            r_cnt <= r_cnt + 2'd1;
            if (r_cnt == 2'd3) begin
                r_last <= i_last;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/imem_stream_loader.sv
// ============================================================================
// Module      : imem_stream_loader
// Description : Loads a byte stream into instruction memory from word 0 up and
//               holds the CPU in reset until the image is complete.
//               Optional macro IMEM_LOADER_CHECKSUM_EN: last word is a checksum.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module imem_stream_loader
    import imem_loader_pkg::*;
#(
    parameter int IM_ADDR_W = IM_ADDR_W_DEFAULT,
    parameter int BYTE_W    = 8
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [BYTE_W-1:0]    in_data,
    input  logic                 in_last,
    input  logic                 reload,
    output logic                 im_we,
    output logic [IM_ADDR_W-1:0] im_addr,
    output logic [31:0]          im_wdata,
    output logic                 cpu_rstn,
    output logic                 done,
    output logic                 err,
    output logic [IM_ADDR_W:0]   words_loaded
);

    localparam logic [IM_ADDR_W:0] C_WORDS_FULL = {1'b0, {IM_ADDR_W{1'b1}}};

    state_t            r_state;
    state_t            w_next;
    logic [IM_ADDR_W:0] r_words;
    logic              r_done;
    logic              r_err;
    logic              r_cpu_rstn;
    logic              w_accept;
    logic              w_restart;
    logic              w_word_done;
    logic              w_partial;
    logic              w_word_last;
    logic [31:0]       w_word;

    assign in_ready  = rstn && (r_state == ST_LOAD);
    assign w_accept  = in_valid && in_ready;
    assign w_restart = reload && ((r_state == ST_DONE) || (r_state == ST_ERR));

    imem_word_packer #(
        .BYTE_W (BYTE_W)
    ) u_packer (
        .clk         (clk),
        .rstn        (rstn),
        .i_clear     (w_restart),
        .i_accept    (w_accept),
        .i_data      (in_data),
        .i_last      (in_last),
        .o_word_done (w_word_done),
        .o_partial   (w_partial),
        .o_word      (w_word),
        .o_word_last (w_word_last)
    );

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [31:0] r_sum;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_sum <= '0;
        end else if (w_restart) begin
            r_sum <= '0;
        end else if (r_state == ST_WRITE) begin
            r_sum <= r_sum + w_word;
        end
    end
`endif

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_LOAD: begin
                if (w_partial) begin
                    w_next = ST_ERR;
                end else if (w_word_done) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    w_next = in_last ? ST_CHECK : ST_WRITE;
`else
                    w_next = ST_WRITE;
`endif
                end
            end
            ST_WRITE: begin
                // A full memory with more data pending is an overflow.
                if (w_word_last) begin
                    w_next = ST_DONE;
                end else if (r_words == C_WORDS_FULL) begin
                    w_next = ST_ERR;
                end else begin
                    w_next = ST_LOAD;
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            ST_CHECK: w_next = (w_word == r_sum) ? ST_DONE : ST_ERR;
`endif
            ST_DONE,
            ST_ERR: begin
                if (w_restart) begin
                    w_next = ST_LOAD;
                end
            end
            default: w_next = ST_LOAD;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state    <= ST_LOAD;
            r_words    <= '0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_cpu_rstn <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_done     <= (w_next == ST_DONE);
            r_err      <= (w_next == ST_ERR);
            r_cpu_rstn <= (w_next == ST_DONE);
            if (w_restart) begin
                r_words <= '0;
            end else if (r_state == ST_WRITE) begin
                r_words <= r_words + 1'b1;
            end
        end
    end

    assign im_we        = (r_state == ST_WRITE);
    assign im_addr      = r_words[IM_ADDR_W-1:0];
    assign im_wdata     = im_we ? w_word : 32'd0;
    assign cpu_rstn     = r_cpu_rstn;
    assign done         = r_done;
    assign err          = r_err;
    assign words_loaded = r_words;

endmodule

`default_nettype wire

// File: tb/tb_imem_stream_loader.sv
// ============================================================================
// Module      : tb_imem_stream_loader
// Description : Scoreboard bench for imem_stream_loader with a small memory.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_imem_stream_loader;

    localparam int AW  = 2;
    localparam int CAP = 1 << AW;

    logic          clk      = 1'b0;
    logic          rstn     = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [7:0]    in_data  = 8'h00;
    logic          in_last  = 1'b0;
    logic          reload   = 1'b0;
    logic          im_we;
    logic [AW-1:0] im_addr;
    logic [31:0]   im_wdata;
    logic          cpu_rstn;
    logic          done;
    logic          err;
    logic [AW:0]   words_loaded;

    int          errors = 0;
    int          checks = 0;
    int          accepted;
    int          exp_addr_q[$];
    logic [31:0] exp_data_q[$];

    imem_stream_loader #(
        .IM_ADDR_W (AW),
        .BYTE_W    (8)
    ) u_dut (
        .clk          (clk),
        .rstn         (rstn),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .in_last      (in_last),
        .reload       (reload),
        .im_we        (im_we),
        .im_addr      (im_addr),
        .im_wdata     (im_wdata),
        .cpu_rstn     (cpu_rstn),
        .done         (done),
        .err          (err),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] word_of(input logic [7:0] b[$], input int k);
        return {b[4*k], b[4*k+1], b[4*k+2], b[4*k+3]};
    endfunction

    // Monitor: every memory write must match the head of the scoreboard.
    always @(negedge clk) begin
        if (rstn && im_we) begin
            if (exp_addr_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: actual addr=%0d data=%h required no write", im_addr, im_wdata);
            end else begin
                check("im_addr", 64'(im_addr), 64'(exp_addr_q.pop_front()));
                check("im_wdata", 64'(im_wdata), 64'(exp_data_q.pop_front()));
                check("in_ready_in_write", 64'(in_ready), 64'd0);
            end
        end
    end

    task automatic send_image(input logic [7:0] b[$], input bit has_last);
        accepted = 0;
        foreach (b[i]) begin
            int w = 0;
            repeat ($urandom_range(0, 2)) begin
                @(negedge clk);
                in_valid = 1'b0;
            end
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = b[i];
            in_last  = has_last && (i == b.size() - 1);
            while (!in_ready && w < 12) begin
                @(negedge clk);
                w++;
            end
            if (!in_ready) begin
                in_valid = 1'b0;
                in_last  = 1'b0;
                break;
            end
            accepted++;
            @(posedge clk);
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic run_image(input string tag, input logic [7:0] b[$], input bit has_last);
        int          len    = b.size();
        int          groups = len / 4;
        int          nwr;
        int          e_acc;
        int          e_lat;
        int          c      = 0;
        bit          e_err;
        logic [31:0] sum    = 32'd0;
        if (!has_last || len > 4 * CAP) begin
            nwr = CAP; e_err = 1'b1; e_acc = 4 * CAP; e_lat = 0;
        end else if (len % 4 != 0) begin
            nwr = groups; e_err = 1'b1; e_acc = len; e_lat = 0;
        end else begin
            nwr = groups; e_err = 1'b0; e_acc = len; e_lat = 1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            nwr = groups - 1;
            for (int k = 0; k < nwr; k++) sum += word_of(b, k);
            e_err = (word_of(b, groups - 1) != sum);
`endif
        end
        for (int k = 0; k < nwr; k++) begin
            exp_addr_q.push_back(k);
            exp_data_q.push_back(word_of(b, k));
        end
        send_image(b, has_last);
        while (!(done || err) && c < 40) begin
            @(negedge clk);
            c++;
        end
        check({tag, ".latency"},  64'(c), 64'(e_lat));
        check({tag, ".done"},     64'(done), 64'(!e_err));
        check({tag, ".err"},      64'(err), 64'(e_err));
        check({tag, ".cpu_rstn"}, 64'(cpu_rstn), 64'(!e_err));
        check({tag, ".words"},    64'(words_loaded), 64'(nwr));
        check({tag, ".accepted"}, 64'(accepted), 64'(e_acc));
        check({tag, ".pending"},  64'(exp_addr_q.size()), 64'd0);
        exp_addr_q.delete();
        exp_data_q.delete();
    endtask

    task automatic do_reload();
        @(negedge clk);
        reload = 1'b1;
        @(negedge clk);
        reload = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, ".in_ready"}, 64'(in_ready), 64'd0);
        check({tag, ".im_we"},    64'(im_we), 64'd0);
        check({tag, ".im_addr"},  64'(im_addr), 64'd0);
        check({tag, ".im_wdata"}, 64'(im_wdata), 64'd0);
        check({tag, ".cpu_rstn"}, 64'(cpu_rstn), 64'd0);
        check({tag, ".done"},     64'(done), 64'd0);
        check({tag, ".err"},      64'(err), 64'd0);
        check({tag, ".words"},    64'(words_loaded), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] q[$];

        repeat (3) @(negedge clk);
        check_reset_values("reset");
        rstn = 1'b1;
        @(negedge clk);
        check("post_reset.in_ready", 64'(in_ready), 64'd1);

        q = '{8'h3C, 8'h08, 8'h10, 8'h01};
        run_image("one_word", q, 1'b1);

        do_reload();
        q = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h20, 8'h09, 8'h00, 8'h05,
              8'h08, 8'h00, 8'h0C, 8'h11};
        run_image("three_words", q, 1'b1);

        do_reload();
        q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        run_image("partial", q, 1'b1);
        do_reload();
        check("reload.err",      64'(err), 64'd0);
        check("reload.done",     64'(done), 64'd0);
        check("reload.cpu_rstn", 64'(cpu_rstn), 64'd0);
        check("reload.words",    64'(words_loaded), 64'd0);
        check("reload.in_ready", 64'(in_ready), 64'd1);

        q.delete();
        for (int i = 0; i < 20; i++) q.push_back(8'($urandom));
        run_image("overflow", q, 1'b0);

        do_reload();
        q = '{8'hAA, 8'hBB};
        send_image(q, 1'b0);
        #2;
        rstn = 1'b0;
        #1;
        check_reset_values("async_reset");
        @(negedge clk);
        rstn = 1'b1;
        q = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
        run_image("after_reset", q, 1'b1);

        for (int n = 0; n < 12; n++) begin
            int len = $urandom_range(1, 4 * CAP + 6);
            do_reload();
            q.delete();
            for (int i = 0; i < len; i++) q.push_back(8'($urandom));
            run_image($sformatf("rand%0d", n), q, 1'b1);
        end

`ifdef IMEM_LOADER_CHECKSUM_EN
        do_reload();
        q = '{8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h02,
              8'h00, 8'h00, 8'h00, 8'h03};
        run_image("csum_good", q, 1'b1);
        do_reload();
        q = '{8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h02,
              8'h00, 8'h00, 8'h00, 8'h04};
        run_image("csum_bad", q, 1'b1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
